boot_loader: RTL

Hardware boot master that fills the pipelined CPU's instruction memory. It accepts a byte stream (valid/ready), assembles big-endian 32-bit instruction words, and drives the `top_pipe` boot port (`boot_up`, `boot_addr`, `boot_datai`, `boot_web`) with one write per word at incrementing addresses. It replaces the testbench-driven boot sequence and sits between the external loader link and `top_pipe`. It reports completion and checksum errors.

---
 rtl/boot_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Boot master: assembles big-endian words from a valid/ready byte stream and
// writes them into the pipelined CPU's instruction memory through its boot port.
module boot_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              boot_up,
  output logic [ADDR_W-1:0] boot_addr,
  output logic [DATA_W-1:0] boot_datai,
  output logic              boot_web,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_CSUM    = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        num_q, num_d;
  logic [7:0]        acc_q, acc_d;
  logic [31:0]       asm_q, asm_d;
  logic              err_q, err_d;
  logic              byte_ready_q, byte_ready_d;
  logic              boot_up_q, boot_up_d;
  logic [ADDR_W-1:0] boot_addr_q, boot_addr_d;
  logic [DATA_W-1:0] boot_datai_q, boot_datai_d;
  logic              boot_web_q, boot_web_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;

  // Registered byte_ready mirrors the current state, so it qualifies acceptance directly.
  assign accept = byte_valid && byte_ready_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    num_d   = num_q;
    acc_d   = acc_q;
    asm_d   = asm_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          err_d   = 1'b0;
          idx_d   = 8'd0;
          acc_d   = 8'd0;
          cnt_d   = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        if (accept) begin
          acc_d = acc_q ^ byte_data;
          if (byte_data == 8'd0) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            num_d   = byte_data;
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          asm_d = {asm_q[23:0], byte_data};
          acc_d = acc_q ^ byte_data;
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_WRITE: begin
        if (idx_q == num_q - 8'd1) begin
          state_d = S_CSUM;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_COLLECT;
        end
      end
      S_CSUM: begin
        if (accept) begin
          err_d   = (byte_data != acc_q);
          state_d = S_FINISH;
        end else begin
          state_d = S_CSUM;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with it after the edge.
    byte_ready_d = (state_d == S_HDR) || (state_d == S_COLLECT) || (state_d == S_CSUM);
    boot_up_d    = byte_ready_d || (state_d == S_WRITE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FINISH);
    boot_web_d   = (state_d != S_WRITE);
    if (state_d == S_WRITE) begin
      boot_addr_d  = ADDR_W'(idx_q);
      boot_datai_d = DATA_W'(asm_d);
    end else begin
      boot_addr_d  = {ADDR_W{1'b0}};
      boot_datai_d = {DATA_W{1'b0}};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      idx_q        <= 8'd0;
      num_q        <= 8'd0;
      acc_q        <= 8'd0;
      asm_q        <= 32'd0;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      boot_up_q    <= 1'b0;
      boot_addr_q  <= {ADDR_W{1'b0}};
      boot_datai_q <= {DATA_W{1'b0}};
      boot_web_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      num_q        <= num_d;
      acc_q        <= acc_d;
      asm_q        <= asm_d;
      err_q        <= err_d;
      byte_ready_q <= byte_ready_d;
      boot_up_q    <= boot_up_d;
      boot_addr_q  <= boot_addr_d;
      boot_datai_q <= boot_datai_d;
      boot_web_q   <= boot_web_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign boot_up    = boot_up_q;
  assign boot_addr  = boot_addr_q;
  assign boot_datai = boot_datai_q;
  assign boot_web   = boot_web_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
